// File: rtl/arbitro_rr.sv
// rtl/arbitro_rr.sv - round-robin drain of NUM_Q input FIFOs into NUM_Q output FIFOs
module arbitro_rr #(
  parameter int DATA_WIDTH = 6,
  parameter int NUM_Q      = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        active,
  input  logic [NUM_Q-1:0]            empty_in,
  input  logic [NUM_Q*DATA_WIDTH-1:0] data_in,
  input  logic [NUM_Q-1:0]            almost_full,
  output logic [NUM_Q-1:0]            pop,
  output logic [NUM_Q-1:0]            push,
  output logic [DATA_WIDTH-1:0]       data_out,
  output logic [1:0]                  arb_state,
  output logic                        idle,
  output logic [7:0]                  grant_count
);

  // Destination field is two bits wide, so the queue count is fixed at four.
  localparam int PTR_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      grant_idx;
  logic                  grant_found;
  logic                  any_req;
  logic                  any_af;
  logic                  serve;
  logic [DATA_WIDTH-1:0] head_word;
  logic [1:0]            head_dest;

  assign any_req   = ~&empty_in;
  assign any_af    = |almost_full;
  // A grant happens only when the upstream machine is active, nothing downstream
  // is near full and there is work; this is evaluated on live inputs each cycle.
  assign serve     = active && !any_af && any_req;
  assign head_dest = head_word[DATA_WIDTH-1 -: 2];

  // Rotating-priority search: first non-empty queue starting at ptr.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_Q; k++) begin
      if (!grant_found && !empty_in[ptr + PTR_W'(k)]) begin
        grant_found = 1'b1;
        grant_idx   = ptr + PTR_W'(k);
      end
    end
  end

  // Select the head word of the granted queue.
  always_comb begin
    head_word = '0;
    for (int k = 0; k < NUM_Q; k++) begin
      if (grant_idx == PTR_W'(k)) begin
        head_word = data_in[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: idle wins over pause when active is low.
  always_comb begin
    state_nxt = ST_IDLE;
    if (active && any_req) begin
      state_nxt = any_af ? ST_PAUSE : ST_SERVE;
    end
  end

  // Pop strobe follows the current-cycle grant decision, not the registered state.
  always_comb begin
    pop = '0;
    if (serve && grant_found) begin
      pop = NUM_Q'(1) << grant_idx;
    end
  end

  // Datapath: forward the granted word one cycle later and advance the rotation.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr         <= '0;
      push        <= '0;
      data_out    <= '0;
      grant_count <= '0;
    end else begin
      push <= '0;
      if (serve && grant_found) begin
        ptr         <= grant_idx + PTR_W'(1);
        data_out    <= head_word;
        push        <= NUM_Q'(1) << head_dest;
        grant_count <= grant_count + 8'd1;
      end
    end
  end

  assign arb_state = state;
  assign idle      = (state == ST_IDLE) && (&empty_in) && !(|push);

endmodule

// File: tb/tb_arbitro_rr.sv
// tb/tb_arbitro_rr.sv - scoreboard bench for arbitro_rr against a queue-level model
module tb_arbitro_rr;

  logic        clk;
  logic        reset;
  logic        active;
  logic [3:0]  empty_in;
  logic [23:0] data_in;
  logic [3:0]  almost_full;
  logic [3:0]  pop;
  logic [3:0]  push;
  logic [5:0]  data_out;
  logic [1:0]  arb_state;
  logic        idle;
  logic [7:0]  grant_count;

  arbitro_rr #(.DATA_WIDTH(6), .NUM_Q(4)) dut (
    .clk(clk), .reset(reset), .active(active), .empty_in(empty_in),
    .data_in(data_in), .almost_full(almost_full), .pop(pop), .push(push),
    .data_out(data_out), .arb_state(arb_state), .idle(idle), .grant_count(grant_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side input FIFOs (show-ahead) and reference model state.
  logic [5:0]  fmem [4][256];
  int          rd [4];
  int          wr [4];
  int          mptr;
  int          mcount;
  int          mstate;
  bit          mpush_pend;
  logic [9:0]  sb [$];
  int          total;
  int          passed;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit qne(input int i);
    return wr[i] != rd[i];
  endfunction

  task automatic enq(input int i, input logic [5:0] w);
    fmem[i][wr[i] % 256] = w;
    wr[i]++;
  endtask

  task automatic flush_all();
    for (int i = 0; i < 4; i++) rd[i] = wr[i];
  endtask

  task automatic drive_heads();
    for (int i = 0; i < 4; i++) begin
      empty_in[i] = !qne(i);
      data_in[i*6 +: 6] = qne(i) ? fmem[i][rd[i] % 256] : 6'($urandom);
    end
  endtask

  // One cycle: drive at negedge, check combinational/registered outputs, commit model at posedge.
  task automatic step(input bit act, input logic [3:0] af, input bit rst);
    int         gidx;
    int         c;
    bit         any_ne;
    bit         exp_idle;
    logic [3:0] exp_pop;
    int         nstate;
    logic [5:0] w;
    active      = act;
    almost_full = af;
    reset       = rst;
    drive_heads();
    #1;
    any_ne = 0;
    for (int i = 0; i < 4; i++) if (qne(i)) any_ne = 1;
    gidx = -1;
    if (act && af == 4'd0 && any_ne) begin
      for (int k = 0; k < 4; k++) begin
        c = (mptr + k) % 4;
        if (gidx < 0 && qne(c)) gidx = c;
      end
    end
    exp_pop  = (gidx >= 0) ? 4'(1 << gidx) : 4'd0;
    exp_idle = (mstate == 0) && !any_ne && !mpush_pend;
    chk("pop", pop, exp_pop);
    chk("arb_state", arb_state, mstate);
    chk("grant_count", grant_count, mcount);
    chk("idle", idle, exp_idle);
    if (!act || !any_ne) nstate = 0;
    else if (af != 4'd0) nstate = 2;
    else nstate = 1;
    @(posedge clk);
    mpush_pend = 0;
    if (gidx >= 0) begin
      w = fmem[gidx][rd[gidx] % 256];
      rd[gidx]++;
      if (!rst) begin
        sb.push_back({4'(1 << w[5:4]), w});
        mpush_pend = 1;
        mptr   = (gidx + 1) % 4;
        mcount = (mcount + 1) % 256;
      end
    end
    if (rst) begin
      mptr   = 0;
      mcount = 0;
      mstate = 0;
    end else begin
      mstate = nstate;
    end
    @(negedge clk);
  endtask

  // Monitor: every push must match the oldest expected word, and every expected word must appear.
  initial begin
    logic [9:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (push !== 4'd0) begin
        if (sb.size() == 0) begin
          chk("unexpected_push", push, 0);
        end else begin
          e = sb.pop_front();
          chk("push", push, e[9:6]);
          chk("data_out", data_out, e[5:0]);
        end
      end else if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("missing_push", push, e[9:6]);
      end
    end
  end

  initial begin
    total = 0; passed = 0;
    mptr = 0; mcount = 0; mstate = 0; mpush_pend = 0;
    for (int i = 0; i < 4; i++) begin rd[i] = 0; wr[i] = 0; end
    reset = 1'b1; active = 1'b0; almost_full = 4'd0; empty_in = 4'hF; data_in = '0;

    // Reset held two cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pop", pop, 0);
    chk("rst_push", push, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_grant_count", grant_count, 0);
    chk("rst_idle", idle, 1);
    chk("rst_arb_state", arb_state, 0);

    // One word per queue, destinations 3,2,1,0.
    enq(0, {2'd3, 4'h1}); enq(1, {2'd2, 4'h2}); enq(2, {2'd1, 4'h3}); enq(3, {2'd0, 4'h4});
    repeat (5) step(1, 4'd0, 0);
    chk("t2_grant_count", grant_count, 4);

    // Only queue 2 busy, then check rotation continues at queue 3.
    enq(2, 6'h05); enq(2, 6'h16); enq(2, 6'h27);
    repeat (4) step(1, 4'd0, 0);
    enq(0, 6'h38); enq(3, 6'h09);
    repeat (3) step(1, 4'd0, 0);

    // Backpressure mid-stream.
    for (int i = 0; i < 4; i++) enq(i, 6'(8 * i + 3));
    step(1, 4'd0, 0);
    step(1, 4'b0010, 0);
    chk("pause_state", arb_state, 2);
    step(1, 4'b0010, 0);
    step(0, 4'b0010, 0);
    repeat (5) step(1, 4'd0, 0);

    // active drops after two grants, then resumes.
    step(0, 4'd0, 1);
    for (int i = 0; i < 4; i++) enq(i, 6'(i * 16 + 10));
    repeat (2) step(1, 4'd0, 0);
    repeat (2) step(0, 4'd0, 0);
    repeat (3) step(1, 4'd0, 0);
    chk("t5_grant_count", grant_count, 4);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      int q;
      logic [3:0] af;
      q = $urandom_range(0, 3);
      if ($urandom_range(0, 2) != 0 && (wr[q] - rd[q]) < 200) enq(q, 6'($urandom));
      af = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'd0;
      step($urandom_range(0, 7) != 0, af, $urandom_range(0, 99) == 0);
    end

    // Wrap of the grant counter after 256 words.
    flush_all();
    step(0, 4'd0, 1);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 64; j++) enq(i, 6'($urandom));
    repeat (257) step(1, 4'd0, 0);
    chk("wrap_grant_count", grant_count, 0);

    // Reset during a pop cycle drops the push.
    enq(1, 6'h2A);
    step(1, 4'd0, 1);
    chk("rst_drop_push", push, 0);
    chk("rst_drop_data", data_out, 0);
    step(0, 4'd0, 0);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
